// File: rtl/btu_pkg.sv
// Shared types and default sizing for the branch target unit.
package btu_pkg;

  localparam int unsigned BTU_XLEN      = 32;
  localparam int unsigned BTU_RAS_DEPTH = 8;
  localparam int unsigned BTU_INC       = 4;
  localparam int unsigned OP_W          = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SEQ    = 2'd0,
    OP_JAL    = 2'd1,
    OP_JALR   = 2'd2,
    OP_BRANCH = 2'd3
  } op_t;

  // Only unconditional jumps may carry call/return hints.
  function automatic logic op_is_jump(input op_t op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/btu_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; push and pop together replace the top entry in place.
module btu_ras
  import btu_pkg::*;
#(
  parameter int unsigned XLEN      = BTU_XLEN,
  parameter int unsigned RAS_DEPTH = BTU_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] din_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  stack_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_idx;
  logic             wr_en;
  logic             full;

  assign top_idx = ptr_q - PTR_W'(1);
  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(RAS_DEPTH));
  assign top_o   = stack_q[top_idx];

  // Pointer/count update and write-slot selection.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (flush_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push_i && pop_i && !empty_o) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_i) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) stack_q[i] <= '0;
    end else if (wr_en) begin
      stack_q[wr_idx] <= din_i;
    end
  end

endmodule

// File: rtl/branch_target_unit.sv
// Registered next-PC / link computation with return-address prediction,
// presented through a single valid/ready output register.
// Optional: define BTU_MISALIGN_CHECK_EN to flag taken targets with bit 1 set.
module branch_target_unit
  import btu_pkg::*;
#(
  parameter int unsigned XLEN      = BTU_XLEN,
  parameter int unsigned RAS_DEPTH = BTU_RAS_DEPTH,
  parameter int unsigned INC       = BTU_INC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  op_t             op_i,
  input  logic            br_taken_i,
  input  logic            is_call_i,
  input  logic            is_ret_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] i_imm_i,
  input  logic [XLEN-1:0] j_imm_i,
  input  logic [XLEN-1:0] b_imm_i,
  input  logic [XLEN-1:0] rs1_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] link_o,
  output logic [XLEN-1:0] ras_pred_o,
  output logic            ras_hit_o,
  output logic            misalign_o
);

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] link_q, link_d;
  logic [XLEN-1:0] ras_pred_q, ras_pred_d;
  logic            ras_hit_q, ras_hit_d;

  logic [XLEN-1:0] link_c, target_c, ras_pred_c;
  logic            call_c, ret_c, ras_hit_c;
  logic            accept, load;
  logic            ras_push, ras_pop;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign load       = accept && !flush_i;
  assign ras_push   = load && call_c;
  assign ras_pop    = load && ret_c;

  // Target adders and op mux; all sums wrap modulo 2^XLEN.
  always_comb begin
    link_c   = pc_i + XLEN'(INC);
    target_c = link_c;
    call_c   = is_call_i && op_is_jump(op_i);
    ret_c    = is_ret_i && op_is_jump(op_i);
    case (op_i)
      OP_JAL:    target_c = pc_i + j_imm_i;
      OP_JALR:   target_c = (rs1_i + i_imm_i) & ~XLEN'(1);
      OP_BRANCH: target_c = br_taken_i ? (pc_i + b_imm_i) : link_c;
      default:   target_c = link_c;
    endcase
  end

  // Prediction reflects the stack before this op updates it.
  always_comb begin
    ras_pred_c = '0;
    ras_hit_c  = 1'b0;
    if (ret_c && !ras_empty) begin
      ras_pred_c = ras_top;
      ras_hit_c  = (ras_top == target_c);
    end
  end

  btu_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .flush_i (flush_i),
    .din_i   (link_c),
    .top_o   (ras_top),
    .empty_o (ras_empty)
  );

  // Output register next-state: flush wins over accept, accept over drain.
  always_comb begin
    out_valid_d = out_valid_q;
    target_d    = target_q;
    link_d      = link_q;
    ras_pred_d  = ras_pred_q;
    ras_hit_d   = ras_hit_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      target_d    = target_c;
      link_d      = link_c;
      ras_pred_d  = ras_pred_c;
      ras_hit_d   = ras_hit_c;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      target_q    <= '0;
      link_q      <= '0;
      ras_pred_q  <= '0;
      ras_hit_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      target_q    <= target_d;
      link_q      <= link_d;
      ras_pred_q  <= ras_pred_d;
      ras_hit_q   <= ras_hit_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign target_o    = target_q;
  assign link_o      = link_q;
  assign ras_pred_o  = ras_pred_q;
  assign ras_hit_o   = ras_hit_q;

`ifdef BTU_MISALIGN_CHECK_EN
  logic taken_c;
  logic misalign_q, misalign_d;

  // Taken control transfers landing off a 4-byte boundary.
  always_comb begin
    taken_c    = op_is_jump(op_i) || ((op_i == OP_BRANCH) && br_taken_i);
    misalign_d = misalign_q;
    if (load) misalign_d = taken_c && target_c[1];
  end

  // Misalign flag register, loaded alongside the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_branch_target_unit.sv
// Scoreboard bench for branch_target_unit: a queue-based reference stack and
// arithmetic target rules produce expectations; a monitor compares in order.
module tb_branch_target_unit;
  import btu_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  op_t         op_i = OP_SEQ;
  logic        br_taken_i = 1'b0, is_call_i = 1'b0, is_ret_i = 1'b0;
  logic [31:0] pc_i = '0, i_imm_i = '0, j_imm_i = '0, b_imm_i = '0, rs1_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] target_o, link_o, ras_pred_o;
  logic        ras_hit_o, misalign_o;

  typedef struct packed {
    logic [31:0] tgt;
    logic [31:0] link;
    logic [31:0] pred;
    logic        hit;
    logic        mis;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] ras_m[$];
  int          checks = 0;
  int          failures = 0;
  logic        rdy_rand = 1'b0;

  branch_target_unit dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .br_taken_i(br_taken_i), .is_call_i(is_call_i), .is_ret_i(is_ret_i),
    .pc_i(pc_i), .i_imm_i(i_imm_i), .j_imm_i(j_imm_i), .b_imm_i(b_imm_i), .rs1_i(rs1_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .target_o(target_o), .link_o(link_o), .ras_pred_o(ras_pred_o),
    .ras_hit_o(ras_hit_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: next PC and return prediction from the architectural rules.
  task automatic model_step(input op_t op, input logic tk, input logic cl, input logic rt,
                            input logic [31:0] pc, input logic [31:0] ii, input logic [31:0] jj,
                            input logic [31:0] bb, input logic [31:0] r1);
    exp_t e;
    logic jump, callv, retv, taken, empty;
    jump  = (op == OP_JAL) || (op == OP_JALR);
    callv = cl && jump;
    retv  = rt && jump;
    e.link = pc + 32'd4;
    taken = 1'b1;
    case (op)
      OP_SEQ:  begin e.tgt = pc + 32'd4; taken = 1'b0; end
      OP_JAL:  e.tgt = pc + jj;
      OP_JALR: e.tgt = {r1 + ii} & 32'hFFFF_FFFE;
      default: begin e.tgt = tk ? pc + bb : pc + 32'd4; taken = tk; end
    endcase
    empty  = (ras_m.size() == 0);
    e.pred = (retv && !empty) ? ras_m[ras_m.size()-1] : 32'd0;
    e.hit  = retv && !empty && (e.pred == e.tgt);
`ifdef BTU_MISALIGN_CHECK_EN
    e.mis = taken && e.tgt[1];
`else
    e.mis = 1'b0;
`endif
    if (callv && retv) begin
      if (empty) ras_m.push_back(e.link);
      else ras_m[ras_m.size()-1] = e.link;
    end else if (callv) begin
      ras_m.push_back(e.link);
      if (ras_m.size() > DEPTH) void'(ras_m.pop_front());
    end else if (retv && !empty) begin
      void'(ras_m.pop_back());
    end
    expq.push_back(e);
  endtask

  // Drive one request (called just after a rising edge); returns just after the accepting edge.
  task automatic issue(input op_t op, input logic tk, input logic cl, input logic rt,
                       input logic [31:0] pc, input logic [31:0] ii, input logic [31:0] jj,
                       input logic [31:0] bb, input logic [31:0] r1, input logic fl);
    int n;
    n = 0;
    in_valid_i = 1'b1; op_i = op; br_taken_i = tk; is_call_i = cl; is_ret_i = rt;
    pc_i = pc; i_imm_i = ii; j_imm_i = jj; b_imm_i = bb; rs1_i = r1; flush_i = fl;
    @(negedge clk);
    while (!in_ready_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready_o) begin
      checks++; failures++;
      $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
      in_valid_i = 1'b0; flush_i = 1'b0;
      @(posedge clk); #1;
    end else begin
      if (fl) ras_m.delete();
      else model_step(op, tk, cl, rt, pc, ii, jj, bb, r1);
      @(posedge clk); #1;
      in_valid_i = 1'b0; flush_i = 1'b0;
      if (fl) chk("flush_drops_valid", 32'(out_valid_o), 32'd0);
      else    chk("latency_valid", 32'(out_valid_o), 32'd1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("drain_queue_empty", 32'(expq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: compare every transferred result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      if (expq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output: got target %h expected no output", target_o);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("target", target_o, e.tgt);
        chk("link", link_o, e.link);
        chk("ras_pred", ras_pred_o, e.pred);
        chk("ras_hit", 32'(ras_hit_o), 32'(e.hit));
        chk("misalign", 32'(misalign_o), 32'(e.mis));
      end
    end
  end

  // Random backpressure source.
  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready_i = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r1;
    op_t         rop;
    #1;
    chk("reset_valid", 32'(out_valid_o), 32'd0);
    chk("reset_target", target_o, 32'd0);
    chk("reset_link", link_o, 32'd0);
    chk("reset_pred", ras_pred_o, 32'd0);
    chk("reset_in_ready", 32'(in_ready_o), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b1;

    // Directed basics: sequential, JALR bit-0 clear, negative branch, wraparound.
    issue(OP_SEQ, 0, 0, 0, 32'h100, 0, 0, 0, 0, 0);
    issue(OP_JALR, 0, 0, 0, 32'h0, 32'h4, 0, 0, 32'h2001, 0);
    issue(OP_BRANCH, 1, 0, 0, 32'h10, 0, 0, 32'hFFFF_FFF8, 0, 0);
    issue(OP_BRANCH, 0, 1, 1, 32'h10, 0, 0, 32'hFFFF_FFF8, 0, 0);
    issue(OP_SEQ, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    issue(OP_JAL, 0, 0, 0, 32'h1000, 0, 32'h2, 0, 0, 0);

    // Two nested calls then matching returns.
    issue(OP_JAL, 0, 1, 0, 32'h40, 0, 32'h100, 0, 0, 0);
    issue(OP_JAL, 0, 1, 0, 32'h80, 0, 32'h100, 0, 0, 0);
    issue(OP_JALR, 0, 0, 1, 32'h300, 32'h4, 0, 0, 32'h80, 0);
    issue(OP_JALR, 0, 0, 1, 32'h304, 32'h4, 0, 0, 32'h40, 0);

    // Overflow: DEPTH+1 calls, DEPTH+1 returns.
    for (int k = 0; k <= DEPTH; k++)
      issue(OP_JAL, 0, 1, 0, 32'(k * 16), 0, 32'h400, 0, 0, 0);
    for (int k = 0; k <= DEPTH; k++)
      issue(OP_JALR, 0, 0, 1, 32'h800, 0, 0, 0, 32'h84 - 32'(k * 16), 0);

    // Call+return in one op: empty stack then non-empty.
    issue(OP_JALR, 0, 1, 1, 32'h900, 0, 0, 0, 32'h44, 0);
    issue(OP_JAL, 0, 1, 1, 32'hA00, 0, 32'h10, 0, 0, 0);
    issue(OP_JALR, 0, 0, 1, 32'hB00, 0, 0, 0, 32'hA04, 0);

    // Backpressure stall.
    drain();
    out_ready_i = 1'b0;
    issue(OP_SEQ, 0, 0, 0, 32'h200, 0, 0, 0, 0, 0);
    in_valid_i = 1'b1; op_i = OP_JAL; pc_i = 32'h300; j_imm_i = 32'h20;
    is_call_i = 1'b0; is_ret_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready_o), 32'd0);
      chk("stall_target_hold", target_o, 32'h204);
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    issue(OP_JAL, 0, 0, 0, 32'h300, 0, 32'h20, 0, 0, 0);

    // Flush with a simultaneous call; following return sees an empty stack.
    issue(OP_JAL, 0, 1, 0, 32'hC00, 0, 32'h8, 0, 0, 0);
    drain();
    issue(OP_JAL, 0, 1, 0, 32'hD00, 0, 32'h8, 0, 0, 1);
    issue(OP_JALR, 0, 0, 1, 32'hE00, 0, 0, 0, 32'hD04, 0);

    // Reset pulse during a stall.
    drain();
    issue(OP_JAL, 0, 1, 0, 32'hF00, 0, 32'h8, 0, 0, 0);
    drain();
    out_ready_i = 1'b0;
    issue(OP_SEQ, 0, 0, 0, 32'h500, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pre_reset_stall", 32'(in_ready_o), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_valid", 32'(out_valid_o), 32'd0);
    chk("midreset_target", target_o, 32'd0);
    chk("midreset_link", link_o, 32'd0);
    chk("midreset_hit", 32'(ras_hit_o), 32'd0);
    chk("midreset_in_ready", 32'(in_ready_o), 32'd1);
    expq.delete();
    ras_m.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    issue(OP_JALR, 0, 0, 1, 32'h600, 0, 0, 0, 32'hF04, 0);

    // Randomized traffic with random backpressure.
    rdy_rand = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
      rop = op_t'($urandom_range(0, 3));
      r1  = $urandom;
      if ($urandom_range(0, 1) == 1 && ras_m.size() != 0) r1 = ras_m[ras_m.size()-1];
      issue(rop, 1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom,
            $urandom, $urandom, r1, 0);
    end
    rdy_rand = 1'b0;
    out_ready_i = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
